imem_bus_arb: RTL and testbench
===============================

Name: imem_bus_arb

Overview:
- Two-requester arbiter sharing one core memory request bus.
- Port s0 is the instruction fetch unit: read-only, flushable. Port s1 is the load/store unit: read or write.
- Requests are forwarded to the m port with zero added latency.
- In-order responses are routed back using an outstanding-source FIFO. Killed fetch responses are dropped.
- Starvation guard: s1 has priority, but s0 is never starved beyond a bounded wait.

Parameters:
- OUTSTANDING, 2: maximum accepted-but-unanswered m transactions (1..8).
- STARVE_LIMIT, 4: consecutive cycles s0 may wait before it is forced priority (1..15).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- s0_req_valid  in  1  fetch request valid
- s0_req_ready  out  1  fetch request accepted
- s0_req_addr  in  32  fetch address
- s0_flush  in  1  kill all outstanding fetch responses
- s0_resp_valid  out  1  fetch response valid
- s0_resp_data  out  32  fetch response data
- s1_req_valid  in  1  LSU request valid
- s1_req_ready  out  1  LSU request accepted
- s1_req_write  in  1  1 = write, 0 = read
- s1_req_addr  in  32  LSU address
- s1_req_wdata  in  32  write data
- s1_req_wstrb  in  4  byte enables
- s1_resp_valid  out  1  LSU response valid (reads and write acks)
- s1_resp_data  out  32  LSU read data
- m_req_valid  out  1  bus request valid
- m_req_ready  in  1  bus request accepted
- m_req_write  out  1  bus write
- m_req_addr  out  32  bus address
- m_req_wdata  out  32  bus write data
- m_req_wstrb  out  4  bus byte enables
- m_resp_valid  in  1  bus response, in order, no backpressure
- m_resp_data  in  32  bus response data
- err_resp  out  1  sticky: response arrived with empty FIFO

Behaviour:
- Reset: FIFO empty, starvation counter 0, lock clear, err_resp 0. All valid/ready outputs are 0 while rst is high.
- Grant is combinational:
  - If lock is set, the locked source wins.
  - Else if starve_cnt >= STARVE_LIMIT and s0_req_valid, s0 wins.
  - Else s1 wins if valid, otherwise s0.
- Muxing:
  - m_req_* is driven from the granted source.
  - For s0: m_req_write=0, wdata=0, wstrb=4'hf.
- m_req_valid = granted source valid AND FIFO not full AND NOT (s0 granted AND s0_flush).
- Ready: sX_req_ready = m_req_ready AND grantX AND m_req_valid. The non-granted ready is 0.
- Lock:
  - Set when m_req_valid is high and m_req_ready is low; it records the granted source.
  - Cleared on handshake.
  - A lock held for s0 is also cleared by s0_flush.
  - This keeps m_req_* stable while valid is pending.
- Starvation counter:
  - +1 (saturating at 15) in each cycle where s0_req_valid is high and s0 does not handshake.
  - Cleared on an s0 handshake or when s0_req_valid is low.
- Outstanding FIFO:
  - Depth OUTSTANDING. Each entry is {src, kill}.
  - Push {grant, 0} on m handshake. Pop on m_resp_valid.
  - Full (count == OUTSTANDING) blocks new requests, even when a pop happens in the same cycle.
  - Push and pop in the same non-full cycle leave the count unchanged.
  - Pointers wrap modulo OUTSTANDING.
- Response routing (combinational, same cycle as m_resp_valid), using the head entry:
  - src=1 → s1_resp_valid=1.
  - src=0, kill=0, and s0_flush low → s0_resp_valid=1.
  - src=0 with kill=1 → popped silently.
  - Response data equals m_resp_data; it is zero when the matching valid is low.
- s0_flush:
  - Sets kill on every valid src=0 entry in the same cycle.
  - A head response for s0 arriving in the flush cycle is suppressed.
  - s0 gets no grant in the flush cycle, so s1 may be granted.
- m_resp_valid with an empty FIFO: nothing is routed, err_resp is set and stays high until reset.
- rst asserted mid-transaction: all state clears immediately. Late m responses after reset then set err_resp (intended).

Test Plan:
- s0 only, m_req_ready=1, fetch 0x100 then 0x104; responses 0xAAAA0001, 0xAAAA0002 one cycle later each → s0_resp_data in order. s1_resp_valid never asserts.
- s0 and s1 both valid continuously, STARVE_LIMIT=4 → s1 granted 4 cycles, s0 granted on cycle 5, counter returns to 0.
- s1 write to 0x2000 (wdata 0xDEADBEEF, wstrb 4'b0011) with m_req_ready low 3 cycles while s0 raises valid → m_req_* stays the s1 write until handshake, then s0 is granted.
- OUTSTANDING=2: two s0 fetches accepted with no response → m_req_valid 0 and s0_req_ready 0. After one response, the next fetch is accepted the following cycle.
- Outstanding FIFO holds s0, s1, s0; pulse s0_flush, then 3 responses → only s1_resp_valid pulses, on the 2nd response.
- m_resp_valid with empty FIFO → err_resp goes 1 and stays 1. Asserting rst → err_resp 0.

Source files
------------

// File: rtl/imem_bus_arb.sv
// Fetch/LSU arbiter onto one memory request bus, with in-order
// response routing through an outstanding-source FIFO.
module imem_bus_arb #(
    parameter int OUTSTANDING  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_req_valid,
    output logic        s0_req_ready,
    input  logic [31:0] s0_req_addr,
    input  logic        s0_flush,
    output logic        s0_resp_valid,
    output logic [31:0] s0_resp_data,
    input  logic        s1_req_valid,
    output logic        s1_req_ready,
    input  logic        s1_req_write,
    input  logic [31:0] s1_req_addr,
    input  logic [31:0] s1_req_wdata,
    input  logic [3:0]  s1_req_wstrb,
    output logic        s1_resp_valid,
    output logic [31:0] s1_resp_data,
    output logic        m_req_valid,
    input  logic        m_req_ready,
    output logic        m_req_write,
    output logic [31:0] m_req_addr,
    output logic [31:0] m_req_wdata,
    output logic [3:0]  m_req_wstrb,
    input  logic        m_resp_valid,
    input  logic [31:0] m_resp_data,
    output logic        err_resp
);

    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);

    logic                   lock;
    logic                   lock_src;
    logic [3:0]             starve_cnt;
    logic [OUTSTANDING-1:0] fifo_src;
    logic [OUTSTANDING-1:0] fifo_kill;
    logic [PW-1:0]          wptr;
    logic [PW-1:0]          rptr;
    logic [CW-1:0]          count;

    logic grant1;
    logic gvalid;
    logic full;
    logic empty;
    logic m_hs;
    logic s0_hs;
    logic pop;
    logic head_src;
    logic head_kill;

    // A fetch lock is abandoned on flush so the LSU can use the slot.
    always_comb begin
        grant1 = s1_req_valid;
        if (lock && !(s0_flush && !lock_src)) begin
            grant1 = lock_src;
        end else if (s0_flush) begin
            grant1 = s1_req_valid;
        end else if (starve_cnt >= 4'(STARVE_LIMIT) && s0_req_valid) begin
            grant1 = 1'b0;
        end
    end

    assign full   = (count == CW'(OUTSTANDING));
    assign empty  = (count == '0);
    assign gvalid = grant1 ? s1_req_valid : s0_req_valid;

    assign m_req_valid = !rst && gvalid && !full && !(!grant1 && s0_flush);
    assign m_req_write = grant1 & s1_req_write;
    assign m_req_addr  = grant1 ? s1_req_addr : s0_req_addr;
    assign m_req_wdata = grant1 ? s1_req_wdata : 32'h0;
    assign m_req_wstrb = grant1 ? s1_req_wstrb : 4'hf;

    assign m_hs         = m_req_valid && m_req_ready;
    assign s0_hs        = m_hs && !grant1;
    assign s0_req_ready = m_hs && !grant1;
    assign s1_req_ready = m_hs && grant1;

    assign pop       = m_resp_valid && !empty && !rst;
    assign head_src  = fifo_src[rptr];
    assign head_kill = fifo_kill[rptr];

    assign s1_resp_valid = pop && head_src;
    assign s0_resp_valid = pop && !head_src && !head_kill && !s0_flush;
    assign s1_resp_data  = s1_resp_valid ? m_resp_data : 32'h0;
    assign s0_resp_data  = s0_resp_valid ? m_resp_data : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock     <= 1'b0;
            lock_src <= 1'b0;
        end else if (m_hs) begin
            lock <= 1'b0;
        end else if (m_req_valid && !m_req_ready) begin
            lock     <= 1'b1;
            lock_src <= grant1;
        end else if (lock && !lock_src && s0_flush) begin
            lock <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!s0_req_valid || s0_hs) begin
            starve_cnt <= '0;
        end else if (starve_cnt != 4'hf) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Stale kill bits on free slots are harmless: a push rewrites them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_src  <= '0;
            fifo_kill <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
        end else begin
            if (s0_flush) begin
                for (int i = 0; i < OUTSTANDING; i++) begin
                    if (!fifo_src[i]) fifo_kill[i] <= 1'b1;
                end
            end
            if (m_hs) begin
                fifo_src[wptr]  <= grant1;
                fifo_kill[wptr] <= 1'b0;
                wptr <= (wptr == PW'(OUTSTANDING - 1)) ? '0 : wptr + 1'b1;
            end
            if (pop) begin
                rptr <= (rptr == PW'(OUTSTANDING - 1)) ? '0 : rptr + 1'b1;
            end
            unique case ({m_hs, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_resp <= 1'b0;
        end else if (m_resp_valid && empty) begin
            err_resp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_bus_arb.sv
// Directed bench for imem_bus_arb: one task per scenario.
// A second, 4-deep instance shares the inputs for the flush scenario.
module tb_imem_bus_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_req_valid, s0_flush;
    logic [31:0] s0_req_addr;
    logic        s1_req_valid, s1_req_write;
    logic [31:0] s1_req_addr, s1_req_wdata;
    logic [3:0]  s1_req_wstrb;
    logic        m_req_ready, m_resp_valid;
    logic [31:0] m_resp_data;

    logic        s0_req_ready, s0_resp_valid, s1_req_ready, s1_resp_valid;
    logic [31:0] s0_resp_data, s1_resp_data, m_req_addr, m_req_wdata;
    logic        m_req_valid, m_req_write, err_resp;
    logic [3:0]  m_req_wstrb;

    logic        f_s0_req_ready, f_s0_resp_valid, f_s1_req_ready, f_s1_resp_valid;
    logic [31:0] f_s0_resp_data, f_s1_resp_data, f_m_req_addr, f_m_req_wdata;
    logic        f_m_req_valid, f_m_req_write, f_err_resp;
    logic [3:0]  f_m_req_wstrb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imem_bus_arb #(.OUTSTANDING(2), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .rst(rst),
        .s0_req_valid(s0_req_valid), .s0_req_ready(s0_req_ready),
        .s0_req_addr(s0_req_addr), .s0_flush(s0_flush),
        .s0_resp_valid(s0_resp_valid), .s0_resp_data(s0_resp_data),
        .s1_req_valid(s1_req_valid), .s1_req_ready(s1_req_ready),
        .s1_req_write(s1_req_write), .s1_req_addr(s1_req_addr),
        .s1_req_wdata(s1_req_wdata), .s1_req_wstrb(s1_req_wstrb),
        .s1_resp_valid(s1_resp_valid), .s1_resp_data(s1_resp_data),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_write(m_req_write), .m_req_addr(m_req_addr),
        .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
        .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data),
        .err_resp(err_resp)
    );

    imem_bus_arb #(.OUTSTANDING(4), .STARVE_LIMIT(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .s0_req_valid(s0_req_valid), .s0_req_ready(f_s0_req_ready),
        .s0_req_addr(s0_req_addr), .s0_flush(s0_flush),
        .s0_resp_valid(f_s0_resp_valid), .s0_resp_data(f_s0_resp_data),
        .s1_req_valid(s1_req_valid), .s1_req_ready(f_s1_req_ready),
        .s1_req_write(s1_req_write), .s1_req_addr(s1_req_addr),
        .s1_req_wdata(s1_req_wdata), .s1_req_wstrb(s1_req_wstrb),
        .s1_resp_valid(f_s1_resp_valid), .s1_resp_data(f_s1_resp_data),
        .m_req_valid(f_m_req_valid), .m_req_ready(m_req_ready),
        .m_req_write(f_m_req_write), .m_req_addr(f_m_req_addr),
        .m_req_wdata(f_m_req_wdata), .m_req_wstrb(f_m_req_wstrb),
        .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data),
        .err_resp(f_err_resp)
    );

    task automatic idle();
        s0_req_valid = 1'b0;
        s0_req_addr  = 32'h0;
        s0_flush     = 1'b0;
        s1_req_valid = 1'b0;
        s1_req_write = 1'b0;
        s1_req_addr  = 32'h0;
        s1_req_wdata = 32'h0;
        s1_req_wstrb = 4'h0;
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b0;
        m_resp_data  = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        s0_req_valid = 1'b1;
        s1_req_valid = 1'b1;
        m_req_ready  = 1'b1;
        m_resp_valid = 1'b1;
        #1;
        checks++;
        if (m_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_m_req_valid got=%0h want=0", m_req_valid);
        end
        checks++;
        if ({s0_req_ready, s1_req_ready} !== 2'b00) begin
            failures++;
            $display("FAIL rst_ready got=%b want=00", {s0_req_ready, s1_req_ready});
        end
        checks++;
        if ({s0_resp_valid, s1_resp_valid} !== 2'b00) begin
            failures++;
            $display("FAIL rst_resp_valid got=%b want=00",
                     {s0_resp_valid, s1_resp_valid});
        end
        @(negedge clk);
        idle();
        rst = 1'b0;
        #1;
        checks++;
        if (err_resp !== 1'b0) begin
            failures++;
            $display("FAIL rst_err_resp got=%0h want=0", err_resp);
        end
    endtask

    task automatic test_fetch();
        @(negedge clk);
        idle();
        m_req_ready  = 1'b1;
        s0_req_valid = 1'b1;
        s0_req_addr  = 32'h100;
        #1;
        checks++;
        if ({m_req_valid, s0_req_ready, m_req_write} !== 3'b110) begin
            failures++;
            $display("FAIL fetch_hs got=%b want=110",
                     {m_req_valid, s0_req_ready, m_req_write});
        end
        checks++;
        if (m_req_addr !== 32'h100 || m_req_wstrb !== 4'hf) begin
            failures++;
            $display("FAIL fetch_addr got=%h/%h want=100/f", m_req_addr, m_req_wstrb);
        end
        @(negedge clk);
        s0_req_addr  = 32'h104;
        m_resp_valid = 1'b1;
        m_resp_data  = 32'hAAAA0001;
        #1;
        checks++;
        if (s0_resp_valid !== 1'b1 || s0_resp_data !== 32'hAAAA0001) begin
            failures++;
            $display("FAIL fetch_resp1 got=%0h/%h want=1/aaaa0001",
                     s0_resp_valid, s0_resp_data);
        end
        checks++;
        if (s0_req_ready !== 1'b1 || m_req_addr !== 32'h104) begin
            failures++;
            $display("FAIL fetch_req2 got=%0h/%h want=1/104", s0_req_ready, m_req_addr);
        end
        @(negedge clk);
        s0_req_valid = 1'b0;
        m_resp_data  = 32'hAAAA0002;
        #1;
        checks++;
        if (s0_resp_valid !== 1'b1 || s0_resp_data !== 32'hAAAA0002) begin
            failures++;
            $display("FAIL fetch_resp2 got=%0h/%h want=1/aaaa0002",
                     s0_resp_valid, s0_resp_data);
        end
        checks++;
        if (s1_resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL fetch_s1_quiet got=%0h want=0", s1_resp_valid);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (s0_resp_valid !== 1'b0 || s0_resp_data !== 32'h0) begin
            failures++;
            $display("FAIL fetch_idle got=%0h/%h want=0/0", s0_resp_valid, s0_resp_data);
        end
    endtask

    task automatic test_starve();
        logic e0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            idle();
            m_req_ready = 1'b1;
            if (c <= 6) begin
                s0_req_valid = 1'b1;
                s0_req_addr  = 32'h200;
                s1_req_valid = 1'b1;
                s1_req_addr  = 32'h4000;
            end
            if (c >= 2) begin
                m_resp_valid = 1'b1;
                m_resp_data  = 32'hB0000000 + 32'(c);
            end
            #1;
            if (c <= 6) begin
                e0 = (c == 5);
                checks++;
                if (s0_req_ready !== e0 || s1_req_ready !== !e0) begin
                    failures++;
                    $display("FAIL starve_grant c=%0d got=%b%b want=%b%b",
                             c, s0_req_ready, s1_req_ready, e0, !e0);
                end
                checks++;
                if (m_req_addr !== (e0 ? 32'h200 : 32'h4000)) begin
                    failures++;
                    $display("FAIL starve_addr c=%0d got=%h", c, m_req_addr);
                end
            end
            if (c >= 2) begin
                checks++;
                if (s0_resp_valid !== (c == 6) || s1_resp_valid !== (c != 6)) begin
                    failures++;
                    $display("FAIL starve_resp c=%0d got=%b%b want=%b%b", c,
                             s0_resp_valid, s1_resp_valid, c == 6, c != 6);
                end
            end
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (err_resp !== 1'b0) begin
            failures++;
            $display("FAIL starve_err got=%0h want=0", err_resp);
        end
    endtask

    task automatic test_lock();
        @(negedge clk);
        idle();
        s1_req_valid = 1'b1;
        s1_req_write = 1'b1;
        s1_req_addr  = 32'h2000;
        s1_req_wdata = 32'hDEADBEEF;
        s1_req_wstrb = 4'b0011;
        #1;
        checks++;
        if ({m_req_valid, m_req_write, s1_req_ready} !== 3'b110) begin
            failures++;
            $display("FAIL lock_first got=%b want=110",
                     {m_req_valid, m_req_write, s1_req_ready});
        end
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            s0_req_valid = 1'b1;
            s0_req_addr  = 32'h600;
            #1;
            checks++;
            if (m_req_addr !== 32'h2000 || m_req_wdata !== 32'hDEADBEEF ||
                m_req_wstrb !== 4'b0011 || m_req_write !== 1'b1) begin
                failures++;
                $display("FAIL lock_hold c=%0d got=%h/%h/%h/%0h", c,
                         m_req_addr, m_req_wdata, m_req_wstrb, m_req_write);
            end
            checks++;
            if ({m_req_valid, s0_req_ready, s1_req_ready} !== 3'b100) begin
                failures++;
                $display("FAIL lock_wait c=%0d got=%b want=100", c,
                         {m_req_valid, s0_req_ready, s1_req_ready});
            end
        end
        @(negedge clk);
        m_req_ready = 1'b1;
        #1;
        checks++;
        if (s1_req_ready !== 1'b1 || s0_req_ready !== 1'b0 || m_req_addr !== 32'h2000) begin
            failures++;
            $display("FAIL lock_hs got=%0h%0h/%h want=10/2000",
                     s1_req_ready, s0_req_ready, m_req_addr);
        end
        @(negedge clk);
        s1_req_valid = 1'b0;
        s1_req_write = 1'b0;
        #1;
        checks++;
        if (s0_req_ready !== 1'b1 || m_req_addr !== 32'h600 || m_req_write !== 1'b0 ||
            m_req_wdata !== 32'h0 || m_req_wstrb !== 4'hf) begin
            failures++;
            $display("FAIL lock_then_s0 got=%0h/%h/%0h/%h/%h", s0_req_ready,
                     m_req_addr, m_req_write, m_req_wdata, m_req_wstrb);
        end
        @(negedge clk);
        idle();
        m_resp_valid = 1'b1;
        m_resp_data  = 32'h1111;
        #1;
        checks++;
        if (s1_resp_valid !== 1'b1 || s1_resp_data !== 32'h1111 || s0_resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL lock_resp_s1 got=%0h/%h/%0h want=1/1111/0",
                     s1_resp_valid, s1_resp_data, s0_resp_valid);
        end
        @(negedge clk);
        m_resp_data = 32'h2222;
        #1;
        checks++;
        if (s0_resp_valid !== 1'b1 || s0_resp_data !== 32'h2222 || s1_resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL lock_resp_s0 got=%0h/%h/%0h want=1/2222/0",
                     s0_resp_valid, s0_resp_data, s1_resp_valid);
        end
    endtask

    task automatic test_full();
        @(negedge clk);
        idle();
        m_req_ready  = 1'b1;
        s0_req_valid = 1'b1;
        s0_req_addr  = 32'h700;
        @(negedge clk);
        s0_req_addr  = 32'h704;
        #1;
        checks++;
        if (s0_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_second got=%0h want=1", s0_req_ready);
        end
        @(negedge clk);
        s0_req_addr  = 32'h708;
        #1;
        checks++;
        if (m_req_valid !== 1'b0 || s0_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_block got=%0h%0h want=00", m_req_valid, s0_req_ready);
        end
        @(negedge clk);
        m_resp_valid = 1'b1;
        m_resp_data  = 32'h7001;
        #1;
        checks++;
        if (m_req_valid !== 1'b0 || s0_resp_valid !== 1'b1 || s0_resp_data !== 32'h7001) begin
            failures++;
            $display("FAIL full_pop_block got=%0h/%0h/%h want=0/1/7001",
                     m_req_valid, s0_resp_valid, s0_resp_data);
        end
        @(negedge clk);
        m_resp_valid = 1'b0;
        #1;
        checks++;
        if (m_req_valid !== 1'b1 || s0_req_ready !== 1'b1 || m_req_addr !== 32'h708) begin
            failures++;
            $display("FAIL full_resume got=%0h%0h/%h want=11/708",
                     m_req_valid, s0_req_ready, m_req_addr);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            idle();
            m_resp_valid = 1'b1;
            m_resp_data  = 32'h7002 + 32'(c);
            #1;
            checks++;
            if (s0_resp_valid !== 1'b1 || s0_resp_data !== 32'h7002 + 32'(c)) begin
                failures++;
                $display("FAIL full_drain c=%0d got=%0h/%h", c, s0_resp_valid, s0_resp_data);
            end
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_flush();
        @(negedge clk);
        idle();
        m_req_ready  = 1'b1;
        s0_req_valid = 1'b1;
        s0_req_addr  = 32'h300;
        @(negedge clk);
        s0_req_valid = 1'b0;
        s1_req_valid = 1'b1;
        s1_req_addr  = 32'h3000;
        @(negedge clk);
        s1_req_valid = 1'b0;
        s0_req_valid = 1'b1;
        s0_req_addr  = 32'h304;
        @(negedge clk);
        s0_flush     = 1'b1;
        s0_req_addr  = 32'h308;
        s1_req_valid = 1'b1;
        s1_req_addr  = 32'h5000;
        #1;
        checks++;
        if ({f_m_req_valid, f_s1_req_ready, f_s0_req_ready} !== 3'b110 ||
            f_m_req_addr !== 32'h5000) begin
            failures++;
            $display("FAIL flush_grant got=%b/%h want=110/5000",
                     {f_m_req_valid, f_s1_req_ready, f_s0_req_ready}, f_m_req_addr);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            idle();
            m_resp_valid = 1'b1;
            m_resp_data  = 32'hC0000000 + 32'(c);
            #1;
            checks++;
            if (f_s0_resp_valid !== 1'b0 || f_s1_resp_valid !== (c % 2 == 0)) begin
                failures++;
                $display("FAIL flush_resp c=%0d got=%0h%0h want=0%0h", c,
                         f_s0_resp_valid, f_s1_resp_valid, c % 2 == 0);
            end
            if (c == 2) begin
                checks++;
                if (f_s1_resp_data !== 32'hC0000002) begin
                    failures++;
                    $display("FAIL flush_data got=%h want=c0000002", f_s1_resp_data);
                end
            end
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (f_err_resp !== 1'b0) begin
            failures++;
            $display("FAIL flush_err got=%0h want=0", f_err_resp);
        end
    endtask

    task automatic test_err();
        @(negedge clk);
        idle();
        m_resp_valid = 1'b1;
        m_resp_data  = 32'h9999;
        #1;
        checks++;
        if ({s0_resp_valid, s1_resp_valid, err_resp} !== 3'b000) begin
            failures++;
            $display("FAIL err_route got=%b want=000",
                     {s0_resp_valid, s1_resp_valid, err_resp});
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (err_resp !== 1'b1) begin
            failures++;
            $display("FAIL err_set got=%0h want=1", err_resp);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (err_resp !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got=%0h want=1", err_resp);
        end
        @(negedge clk);
        rst          = 1'b1;
        s0_req_valid = 1'b1;
        m_req_ready  = 1'b1;
        #1;
        checks++;
        if ({err_resp, m_req_valid, s0_req_ready} !== 3'b000) begin
            failures++;
            $display("FAIL err_clear got=%b want=000", {err_resp, m_req_valid, s0_req_ready});
        end
        @(negedge clk);
        idle();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_fetch();
        test_starve();
        test_lock();
        test_full();
        do_reset();
        test_flush();
        do_reset();
        test_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
